// File: rtl/csa5_accum_seq.sv
// csa5_accum_seq
//   Sequential accumulator controller wrapped around an external 5-bit
//   carry-select adder (csa_5bit). The running total is presented on add_a,
//   the incoming operand on add_b, and the adder's sum/cout are captured back
//   on each accepted beat. At the end of a group (in_last), the total, a
//   sticky overflow flag and a beat count are held on a valid/ready output.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    operand beat handshake
//   in_data, in_last     operand and end-of-group marker
//   add_a, add_b         to adder i_add_term1 / i_add_term2
//   add_sum, add_cout    from adder sum / cout
//   out_valid/out_ready  group result handshake
//   out_sum, out_ovf     group total and sticky carry-out flag
//   out_count            beats accepted in the group (saturating)
//
// Build option
//   CSA5_ACCUM_SAT_EN    when defined, a carry-out clamps the accumulator to
//                        all-ones for the rest of the group instead of wrapping.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | accumulator empty, count 0, ready for beats
// ACC   | at least one beat of the group taken
// DONE  | result held until out_ready

module csa5_accum_seq #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q != S_DONE);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;

  assign add_a     = acc_q;
  assign add_b     = in_data;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
`ifdef CSA5_ACCUM_SAT_EN
          // ovf_q doubles as the "already clamped" flag within a group.
          acc_d = (add_cout | ovf_q) ? {WIDTH{1'b1}} : add_sum;
`else
          acc_d = add_sum;
`endif
          ovf_d = ovf_q | add_cout;
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = in_last ? S_DONE : S_ACC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_csa5_accum_seq.sv
module tb_csa5_accum_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic       in_last;
  logic [4:0] add_a;
  logic [4:0] add_b;
  logic [4:0] add_sum;
  logic       add_cout;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_sum;
  logic       out_ovf;
  logic [3:0] out_count;

  int checks = 0;
  int errors = 0;

  csa5_accum_seq #(.WIDTH(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
  );

  // Behavioural stand-in for the external 5-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven on the falling edge; the rising edge samples them and
  // the task returns at the next falling edge, where outputs are stable.
  task automatic beat(input logic [4:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 5'd0;
  endtask

  task automatic check_result(input string name, input logic [4:0] e_sum,
                              input logic e_ovf, input logic [3:0] e_cnt);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got %0b want 1", name, out_valid); end
    checks++;
    if (out_sum !== e_sum) begin errors++; $display("FAIL %s out_sum got %0d want %0d", name, out_sum, e_sum); end
    checks++;
    if (out_ovf !== e_ovf) begin errors++; $display("FAIL %s out_ovf got %0b want %0b", name, out_ovf, e_ovf); end
    checks++;
    if (out_count !== e_cnt) begin errors++; $display("FAIL %s out_count got %0d want %0d", name, out_count, e_cnt); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready in DONE got %0b want 0", name, in_ready); end
  endtask

  task automatic take_result(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready after take got %0b want 1", name, in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid after take got %0b want 0", name, out_valid); end
    checks++;
    if (add_a !== 5'd0) begin errors++; $display("FAIL %s acc cleared got %0d want 0", name, add_a); end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0; in_data = 5'd0; in_last = 1'b0; out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %0b want 0", out_valid); end
    checks++;
    if (out_sum !== 5'd0) begin errors++; $display("FAIL reset out_sum got %0d want 0", out_sum); end
    checks++;
    if (out_count !== 4'd0) begin errors++; $display("FAIL reset out_count got %0d want 0", out_count); end
    checks++;
    if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset out_ovf got %0b want 0", out_ovf); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %0b want 1", in_ready); end
    checks++;
    if (add_a !== 5'd0) begin errors++; $display("FAIL reset add_a got %0d want 0", add_a); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_group;
    beat(5'd3, 1'b0);
    checks++;
    if (add_a !== 5'd3) begin errors++; $display("FAIL basic add_a after beat1 got %0d want 3", add_a); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic out_valid mid-group got %0b want 0", out_valid); end
    in_data = 5'd4;
    #1;
    checks++;
    if (add_b !== 5'd4) begin errors++; $display("FAIL basic add_b got %0d want 4", add_b); end
    beat(5'd4, 1'b0);
    beat(5'd5, 1'b1);
    check_result("basic", 5'd12, 1'b0, 4'd3);
    take_result("basic");
  endtask

  task automatic test_overflow;
    beat(5'd20, 1'b0);
    beat(5'd15, 1'b1);
`ifdef CSA5_ACCUM_SAT_EN
    check_result("overflow", 5'd31, 1'b1, 4'd2);
`else
    check_result("overflow", 5'd3, 1'b1, 4'd2);
`endif
    take_result("overflow");
  endtask

  // 31 + 1 carries out, then + 1 does not: the flag must stay sticky and,
  // when clamping, the total must stay at 31.
  task automatic test_sticky;
    beat(5'd31, 1'b0);
    beat(5'd1, 1'b0);
    beat(5'd1, 1'b1);
`ifdef CSA5_ACCUM_SAT_EN
    check_result("sticky", 5'd31, 1'b1, 4'd3);
`else
    check_result("sticky", 5'd1, 1'b1, 4'd3);
`endif
    take_result("sticky");
  endtask

  task automatic test_backpressure;
    beat(5'd7, 1'b1);
    // Offer another beat while the result is held; it must not be taken.
    in_valid = 1'b1;
    in_data  = 5'd9;
    for (int i = 0; i < 5; i++) begin
      check_result("backpressure", 5'd7, 1'b0, 4'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 5'd0;
    take_result("backpressure");
  endtask

  task automatic test_reset_mid_group;
    beat(5'd9, 1'b0);
    beat(5'd9, 1'b0);
    checks++;
    if (add_a !== 5'd18) begin errors++; $display("FAIL midreset acc before reset got %0d want 18", add_a); end
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (add_a !== 5'd0 || out_count !== 4'd0) begin
      errors++; $display("FAIL midreset cleared acc=%0d count=%0d want 0 0", add_a, out_count);
    end
    beat(5'd1, 1'b0);
    beat(5'd1, 1'b1);
    check_result("midreset", 5'd2, 1'b0, 4'd2);
    take_result("midreset");
  endtask

  task automatic test_count_saturation;
    for (int i = 0; i < 17; i++) beat(5'd0, (i == 16));
    check_result("countsat", 5'd0, 1'b0, 4'd15);
    take_result("countsat");
  endtask

  task automatic test_back_to_back;
    beat(5'd2, 1'b1);
    check_result("b2b_first", 5'd2, 1'b0, 4'd1);
    take_result("b2b_first");
    beat(5'd6, 1'b0);
    beat(5'd10, 1'b1);
    check_result("b2b_second", 5'd16, 1'b0, 4'd2);
    take_result("b2b_second");
  endtask

  initial begin
    test_reset;
    test_basic_group;
    test_overflow;
    test_sticky;
    test_backpressure;
    test_reset_mid_group;
    test_count_saturation;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
